stream_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that merges the per-subsystem AXI-Stream packet FIFOs (run/capture, ADC stream, TI) into the single 64-bit stream feeding the UDP transmit path.
- Holds a grant for a whole packet, through tlast.
- Enforces a maximum packet length and a stall watchdog, so one broken source cannot block the shared link.
- Keeps per-source packet and abort counters for the register map.

---
 rtl/stream_packet_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_stream_packet_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources into one stream.
// A grant is held for a whole packet. Two mechanisms force a packet to end: a maximum
// packet length, and a stall watchdog that injects an abort beat.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   src_ena            per-source grant enable (only consulted when choosing a new grant)
//   in_t*              packed source streams, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_t*             merged stream; out_tid = granted source, out_tabort = forced end
//   busy               high while a packet is in progress (PASS or ABORT)
//   pkt_count          packets completed per source, 16-bit wrapping
//   abort_count        forced terminations per source, 16-bit saturating
module stream_packet_arbiter #(
  parameter int unsigned           NUM_SRC       = 3,
  parameter int unsigned           DATA_WIDTH    = 64,
  parameter int unsigned           MAX_PKT_BEATS = 1024,
  parameter int unsigned           STALL_CYCLES  = 4096,
  parameter logic [DATA_WIDTH-1:0] ABORT_WORD    = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_ena,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_SRC-1:0]      in_tvalid,
  input  logic [NUM_SRC-1:0]      in_tlast,
  output logic [NUM_SRC-1:0]      in_tready,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  output logic [1:0]              out_tid,
  output logic                    out_tabort,
  input  logic                    out_tready,
  output logic                    busy,
  output logic [NUM_SRC*16-1:0]   pkt_count,
  output logic [NUM_SRC*16-1:0]   abort_count
);

  localparam int unsigned BeatW  = $clog2(MAX_PKT_BEATS);
  localparam int unsigned StallW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(MAX_PKT_BEATS - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPass, StAbort} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                grant_q, grant_d;
  logic [1:0]                rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]          beat_q, beat_d;
  logic [StallW-1:0]         stall_q, stall_d;
  logic [NUM_SRC-1:0][15:0]  pkt_q, pkt_d;
  logic [NUM_SRC-1:0][15:0]  abort_q, abort_d;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting just after the last served source.
  logic [NUM_SRC-1:0] cand;
  logic               found;
  logic [1:0]         winner;
  logic [1:0]         idx;

  always_comb begin
    cand   = in_tvalid & src_ena;
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = 2'((32'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  logic at_limit;
  logic finish;
  logic finish_abort;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_d       = beat_q;
    stall_d      = stall_q;
    pkt_d        = pkt_q;
    abort_d      = abort_q;
    in_tready    = '0;
    out_tdata    = '0;
    out_tvalid   = 1'b0;
    out_tlast    = 1'b0;
    out_tabort   = 1'b0;
    out_tid      = '0;
    finish       = 1'b0;
    finish_abort = 1'b0;
    at_limit     = (beat_q == LastBeat);

    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          beat_d  = '0;
          stall_d = '0;
          state_d = StPass;
        end
      end
      StPass: begin
        out_tdata          = src_data[grant_q];
        out_tvalid         = in_tvalid[grant_q];
        out_tid            = grant_q;
        in_tready[grant_q] = out_tready;
        out_tlast          = in_tlast[grant_q] | at_limit;
        out_tabort         = at_limit & ~in_tlast[grant_q];
        if (in_tvalid[grant_q]) begin
          // A valid source always clears the watchdog, even on its threshold cycle.
          stall_d = '0;
          if (out_tready) begin
            if (out_tlast) begin
              finish       = 1'b1;
              finish_abort = out_tabort;
            end else begin
              beat_d = beat_q + BeatW'(1);
            end
          end
        end else if (beat_q != '0) begin
          if (stall_q == StallLast) begin
            stall_d = '0;
            state_d = StAbort;
          end else begin
            stall_d = stall_q + StallW'(1);
          end
        end
      end
      StAbort: begin
        out_tdata  = ABORT_WORD;
        out_tvalid = 1'b1;
        out_tlast  = 1'b1;
        out_tabort = 1'b1;
        out_tid    = grant_q;
        if (out_tready) begin
          finish       = 1'b1;
          finish_abort = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      pkt_d[grant_q] = pkt_q[grant_q] + 16'd1;
      if (finish_abort && abort_q[grant_q] != 16'hFFFF) begin
        abort_d[grant_q] = abort_q[grant_q] + 16'd1;
      end
      rr_ptr_d = grant_q;
      beat_d   = '0;
      stall_d  = '0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= 2'(NUM_SRC - 1);
      beat_q   <= '0;
      stall_q  <= '0;
      pkt_q    <= '0;
      abort_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
      pkt_q    <= pkt_d;
      abort_q  <= abort_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign pkt_count   = pkt_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench for stream_packet_arbiter. Sources are fed from per-source beat queues;
// the expected output beats of each source (with length-limit splitting) are queued at issue
// time and a monitor pops them by out_tid whenever a beat is accepted.
module tb_stream_packet_arbiter;
  localparam int unsigned NS       = 3;
  localparam int unsigned DW       = 64;
  localparam int unsigned MaxBeats = 8;
  localparam int unsigned StallCyc = 16;
  localparam logic [63:0] AbortWord = 64'hDEAD_BEEF_DEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_ena;
  logic [NS*DW-1:0] in_tdata;
  logic [NS-1:0]    in_tvalid, in_tlast, in_tready;
  logic [DW-1:0]    out_tdata;
  logic             out_tvalid, out_tlast, out_tabort, out_tready, busy;
  logic [1:0]       out_tid;
  logic [NS*16-1:0] pkt_count, abort_count;

  always #4 clk = ~clk;

  stream_packet_arbiter #(
    .NUM_SRC      (NS),
    .DATA_WIDTH   (DW),
    .MAX_PKT_BEATS(MaxBeats),
    .STALL_CYCLES (StallCyc),
    .ABORT_WORD   (AbortWord)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_ena    (src_ena),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
    .out_tabort (out_tabort),
    .out_tready (out_tready),
    .busy       (busy),
    .pkt_count  (pkt_count),
    .abort_count(abort_count)
  );

  int total = 0;
  int bad   = 0;

  logic [64:0] src_q [NS][$];  // {last, data} still to be offered by each source
  logic [65:0] exp_q [NS][$];  // {abort, last, data} expected on the output per source
  int mdl_pkt [NS];
  int mdl_abt [NS];
  int acc_cnt [NS];
  int gap_cnt [NS];
  bit gaps_on;
  int rdy_mode;
  int cyc;
  bit log_en;
  bit mon_sop;
  int sop_tid[$];
  int sop_cyc[$];
  int eop_cyc[$];
  int beat_cyc[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: each source packet is cut into chunks of MaxBeats; a chunk that ends
  // before the source's own tlast is a forced termination.
  task automatic send_pkt(input int i, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      logic [63:0] d;
      bit sl;
      bit lim;
      d   = {$urandom, $urandom};
      sl  = with_last && (k == len - 1);
      lim = ((k % MaxBeats) == MaxBeats - 1);
      src_q[i].push_back({sl, d});
      exp_q[i].push_back({lim && !sl, sl || lim, d});
      if (sl || lim) begin
        mdl_pkt[i]++;
        if (lim && !sl) mdl_abt[i]++;
      end
    end
  endtask

  // One clock: sample handshakes mid-cycle, then update AXI sources and out_tready.
  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = in_tvalid & in_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
      if (src_q[i].size() == 0) begin
        in_tvalid[i] = 1'b0;
      end else if (!(in_tvalid[i] && !hs[i])) begin
        if (gaps_on && gap_cnt[i] < 6 && $urandom_range(3) == 0) begin
          in_tvalid[i] = 1'b0;
          gap_cnt[i]++;
        end else begin
          in_tvalid[i]            = 1'b1;
          in_tlast[i]             = src_q[i][0][64];
          in_tdata[i*DW +: DW]    = src_q[i][0][63:0];
          gap_cnt[i]              = 0;
        end
      end
    end
    case (rdy_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = ~out_tready;
      default: out_tready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      mdl_pkt[i] = 0;
      mdl_abt[i] = 0;
      acc_cnt[i] = 0;
      gap_cnt[i] = 0;
    end
    in_tvalid = '0;
    in_tlast  = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: timeout, got %0d beats pending expected 0", name,
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
  endtask

  task automatic check_counts(input string name);
    for (int i = 0; i < NS; i++) begin
      check({name, "_pkt"}, pkt_count[i*16 +: 16], 16'(mdl_pkt[i]));
      check({name, "_abt"}, abort_count[i*16 +: 16], 16'(mdl_abt[i]));
    end
  endtask

  task automatic clear_logs();
    sop_tid.delete();
    sop_cyc.delete();
    eop_cyc.delete();
    beat_cyc.delete();
  endtask

  // Monitor / scoreboard
  initial begin
    cyc     = 0;
    mon_sop = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_sop = 1'b1;
        continue;
      end
      check("tready_grant", in_tready & ~(busy ? (3'b001 << out_tid) : 3'b000), 0);
      if (out_tvalid && out_tready) begin
        if (out_tid >= NS || exp_q[out_tid].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tid=%0d data=%0h expected no beat", out_tid,
                   out_tdata);
        end else begin
          logic [65:0] e;
          e = exp_q[out_tid].pop_front();
          check("beat", {out_tabort, out_tlast, out_tdata}, e);
          if (log_en) begin
            if (mon_sop) begin
              sop_tid.push_back(int'(out_tid));
              sop_cyc.push_back(cyc);
            end
            if (out_tlast) eop_cyc.push_back(cyc);
            beat_cyc.push_back(cyc);
          end
        end
        mon_sop = out_tlast;
      end
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    src_ena    = '1;
    in_tvalid  = '0;
    in_tlast   = '0;
    in_tdata   = '0;
    out_tready = 1'b1;
    gaps_on    = 1'b0;
    rdy_mode   = 0;
    log_en     = 1'b0;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tlast_abort", {out_tlast, out_tabort}, 0);
    check("rst_tid_data", {out_tid, out_tdata}, 0);
    check("rst_tready", in_tready, 0);
    check("rst_counts", {pkt_count, abort_count}, 0);

    // Round-robin fairness
    clear_logs();
    log_en = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++) send_pkt(i, 4, 1'b1);
    wait_drain(200, "rr_drain");
    check("rr_npkts", sop_tid.size(), 6);
    for (int k = 0; k < 6 && k < sop_tid.size(); k++) check("rr_tid", sop_tid[k], k % 3);
    for (int k = 0; k < 5 && k < sop_cyc.size() - 1 && k < eop_cyc.size(); k++)
      check("rr_bubble", sop_cyc[k+1] - eop_cyc[k], 2);
    for (int i = 0; i < NS; i++) check("rr_pkt_count", pkt_count[i*16 +: 16], 2);
    log_en = 1'b0;

    // Backpressure
    do_reset();
    rdy_mode = 1;
    send_pkt(1, 5, 1'b1);
    wait_drain(200, "bp_drain");
    check_counts("bp");
    rdy_mode = 0;

    // Length limit
    do_reset();
    send_pkt(0, 12, 1'b1);
    wait_drain(200, "len_drain");
    check("len_abort0", abort_count[15:0], 1);
    check("len_pkt0", pkt_count[15:0], 2);

    // Stall abort
    do_reset();
    clear_logs();
    log_en = 1'b1;
    send_pkt(2, 3, 1'b0);
    exp_q[2].push_back({1'b1, 1'b1, AbortWord});
    mdl_pkt[2]++;
    mdl_abt[2]++;
    wait_drain(200, "stall_drain");
    check("stall_nbeats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("stall_delay", beat_cyc[3] - beat_cyc[2], StallCyc + 1);
    check("stall_abort2", abort_count[47:32], 1);
    check("stall_idle", busy, 0);
    log_en = 1'b0;

    // Enable mask
    do_reset();
    src_ena = 3'b101;
    send_pkt(0, 6, 1'b1);
    send_pkt(1, 3, 1'b1);
    send_pkt(2, 3, 1'b1);
    n = 0;
    while (acc_cnt[0] < 2 && n < 100) begin tick(); n++; end
    check("ena_src0_started", acc_cnt[0] >= 2, 1);
    src_ena = 3'b100;
    n = 0;
    while ((exp_q[0].size() + exp_q[2].size()) != 0 && n < 200) begin tick(); n++; end
    check("ena_02_done", exp_q[0].size() + exp_q[2].size(), 0);
    repeat (5) tick();
    check("ena_src1_blocked", acc_cnt[1], 0);
    src_ena = 3'b111;
    wait_drain(200, "ena_drain");
    check_counts("ena");

    // Reset mid-packet
    do_reset();
    send_pkt(1, 2, 1'b1);
    wait_drain(100, "rstmid_pre");
    send_pkt(0, 6, 1'b1);
    n = 0;
    while (acc_cnt[0] < 1 && n < 100) begin tick(); n++; end
    check("rstmid_busy_before", busy, 1);
    do_reset();
    check("rstmid_tvalid", out_tvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_counts", {pkt_count, abort_count}, 0);
    clear_logs();
    log_en = 1'b1;
    send_pkt(1, 2, 1'b1);
    send_pkt(0, 2, 1'b1);
    wait_drain(100, "rstmid_drain");
    check("rstmid_first_tid", sop_tid.size() > 0 ? sop_tid[0] : -1, 0);
    log_en = 1'b0;

    // Randomized traffic
    do_reset();
    gaps_on  = 1'b1;
    rdy_mode = 2;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(NS - 1), $urandom_range(12, 1), 1'b1);
      src_ena = 3'($urandom_range(7));
      repeat ($urandom_range(8)) tick();
    end
    src_ena = 3'b111;
    wait_drain(5000, "rand_drain");
    check_counts("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
